// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter slice.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 7->0.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[IDX_W'(ptr + IDX_W'(i))];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any = |req;
    idx = IDX_W'(ptr + off);
  end

endmodule : rr_pick8

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with optional hold limit; drives a 3-to-8 decoder.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt
);

  localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST    = HOLD_LIMITED ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic             valid_n;
  logic [IDX_W-1:0] idx_n;
  logic [N_REQ-1:0] gnt_n;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             release_c;

  // rr_ptr already sits one past the current holder, so the holder is searched last.
  rr_pick8 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      gnt       <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      hold_cnt  <= hold_n;
      gnt_valid <= valid_n;
      gnt_idx   <= idx_n;
      gnt       <= gnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    hold_n    = hold_cnt;
    valid_n   = gnt_valid;
    idx_n     = gnt_idx;
    release_c = !req[gnt_idx] || (HOLD_LIMITED && (hold_cnt == HOLD_LAST));

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n  = GRANT;
          valid_n  = 1'b1;
          idx_n    = pick_idx;
          rr_ptr_n = IDX_W'(pick_idx + IDX_W'(1));
          hold_n   = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          if (pick_any) begin
            idx_n    = pick_idx;
            rr_ptr_n = IDX_W'(pick_idx + IDX_W'(1));
            hold_n   = '0;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
          end
        end else if (!(&hold_cnt)) begin
          hold_n = CNT_W'(hold_cnt + CNT_W'(1));
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase

    // One-hot grant follows the next-state index so it stays aligned with gnt_idx.
    gnt_n = valid_n ? (N_REQ'(1) << idx_n) : '0;
  end

endmodule : rr_arbiter_8

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench: unlimited-hold and MAX_HOLD=4 arbiters against a reference model.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic       gv_a, gv_b;
  logic [2:0] gi_a, gi_b;
  logic [7:0] g_a, g_b;

  int n_chk  = 0;
  int n_fail = 0;

  rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(8)) u_unl (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt_valid(gv_a), .gnt_idx(gi_a), .gnt(g_a)
  );

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) u_lim (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt_valid(gv_b), .gnt_idx(gi_b), .gnt(g_b)
  );

  always #5 clk = ~clk;

  // Reference model: owner index, next search start and cycles already held.
  typedef struct {
    bit valid;
    int idx;
    int ptr;
    int held;
  } mdl_t;

  mdl_t mdl_a, mdl_b;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.valid = 0; m.idx = 0; m.ptr = 0; m.held = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic [7:0] r, int max_hold);
    int cand;
    cand = -1;
    if (m.valid) begin
      if (r[m.idx] && !(max_hold > 0 && m.held + 1 >= max_hold)) begin
        m.held = m.held + 1;
        return m;
      end
    end else if (r == 8'h00) begin
      return m;
    end
    for (int k = 0; k < 8; k++) begin
      if (cand < 0 && r[(m.ptr + k) % 8]) cand = (m.ptr + k) % 8;
    end
    if (cand < 0) begin
      m.valid = 0;
    end else begin
      m.valid = 1;
      m.idx   = cand;
      m.ptr   = (cand + 1) % 8;
      m.held  = 0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    logic [7:0] ea, eb;
    ea = mdl_a.valid ? (8'h01 << mdl_a.idx) : 8'h00;
    eb = mdl_b.valid ? (8'h01 << mdl_b.idx) : 8'h00;
    chk("unl_valid", 32'(gv_a), 32'(mdl_a.valid));
    chk("unl_idx",   32'(gi_a), 32'(mdl_a.idx));
    chk("unl_gnt",   32'(g_a),  32'(ea));
    chk("lim_valid", 32'(gv_b), 32'(mdl_b.valid));
    chk("lim_idx",   32'(gi_b), 32'(mdl_b.idx));
    chk("lim_gnt",   32'(g_b),  32'(eb));
  endtask

  // One clock: drive after a falling edge, model at the rising edge, check at the next fall.
  task automatic step(input logic [7:0] ra, input logic [7:0] rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    mdl_a = mdl_step(mdl_a, ra, 0);
    mdl_b = mdl_step(mdl_b, rb, 4);
    @(negedge clk);
    chk_models();
  endtask

  task automatic do_reset();
    req_a = 8'h00;
    req_b = 8'h00;
    rst_n = 1'b0;
    mdl_a = mdl_reset();
    mdl_b = mdl_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       v;
    logic [2:0] idx;
    logic [7:0] g;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;

    tbl[0]  = '{8'h00, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{8'h04, 1'b1, 3'd2, 8'h04};
    tbl[2]  = '{8'h04, 1'b1, 3'd2, 8'h04};
    tbl[3]  = '{8'h0C, 1'b1, 3'd2, 8'h04};
    tbl[4]  = '{8'h08, 1'b1, 3'd3, 8'h08};
    tbl[5]  = '{8'h81, 1'b1, 3'd7, 8'h80};
    tbl[6]  = '{8'h81, 1'b1, 3'd7, 8'h80};
    tbl[7]  = '{8'h01, 1'b1, 3'd0, 8'h01};
    tbl[8]  = '{8'h00, 1'b0, 3'd0, 8'h00};
    tbl[9]  = '{8'h06, 1'b1, 3'd1, 8'h02};
    tbl[10] = '{8'h04, 1'b1, 3'd2, 8'h04};
    tbl[11] = '{8'h00, 1'b0, 3'd2, 8'h00};

    // Reset, then idle requests for 10 cycles.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(8'h00, 8'h00);
      chk("idle_valid", 32'(gv_a), 32'd0);
      chk("idle_gnt",   32'(g_a),  32'd0);
      chk("idle_idx",   32'(gi_a), 32'd0);
    end

    // Directed vectors on the unlimited arbiter.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req, 8'h00);
      chk($sformatf("vec%0d_valid", i), 32'(gv_a), 32'(tbl[i].v));
      chk($sformatf("vec%0d_idx", i),   32'(gi_a), 32'(tbl[i].idx));
      chk($sformatf("vec%0d_gnt", i),   32'(g_a),  32'(tbl[i].g));
    end

    // All requesting with MAX_HOLD=4: 0..7 in order, 4 cycles each, no gaps.
    do_reset();
    for (int k = 0; k < 72; k++) begin
      step(8'h00, 8'hFF);
      chk("fair_valid", 32'(gv_b), 32'd1);
      chk("fair_idx",   32'(gi_b), 32'((k / 4) % 8));
    end

    // Sole requester 5: held forever when unlimited, re-granted when limited.
    do_reset();
    for (int k = 0; k < 100; k++) begin
      step(8'h20, 8'h20);
      chk("solo_unl_idx",   32'(gi_a), 32'd5);
      chk("solo_unl_valid", 32'(gv_a), 32'd1);
      chk("solo_lim_idx",   32'(gi_b), 32'd5);
      chk("solo_lim_valid", 32'(gv_b), 32'd1);
    end

    // Asynchronous reset between edges clears outputs before the next clock.
    do_reset();
    repeat (3) step(8'h04, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_unl_valid", 32'(gv_a), 32'd0);
    chk("async_unl_gnt",   32'(g_a),  32'd0);
    chk("async_lim_valid", 32'(gv_b), 32'd0);
    chk("async_lim_gnt",   32'(g_b),  32'd0);
    mdl_a = mdl_reset();
    mdl_b = mdl_reset();
    req_a = 8'h06;
    req_b = 8'h06;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h06, 8'h06);
    chk("post_rst_unl_idx", 32'(gi_a), 32'd1);
    chk("post_rst_lim_idx", 32'(gi_b), 32'd1);

    // Random level requests with occasional toggles, checked against the model.
    do_reset();
    ra = 8'h00;
    rb = 8'h00;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(5) == 0) ra[b] = ~ra[b];
        if ($urandom_range(5) == 0) rb[b] = ~rb[b];
      end
      if ($urandom_range(49) == 0) rb = 8'hFF;
      step(ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter_8
